// File: rtl/dsss_sync_ctrl.sv
// Symbol-boundary acquisition and tracking for a DSSS correlator: search, confirm, then
// sample once per symbol period to produce despread bits, dropping lock after repeated misses.
module dsss_sync_ctrl #(
    parameter int unsigned CW        = 8,
    parameter int unsigned PERIOD    = 31,
    parameter int unsigned HI_TH     = 56,
    parameter int unsigned LO_TH     = 6,
    parameter int unsigned CONFIRM_N = 2,
    parameter int unsigned MISS_MAX  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          chip_en,
    input  logic [CW-1:0] corr,
    input  logic          resync,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          bit_weak,
    output logic          locked,
    output logic [1:0]    state_o
);

    localparam int unsigned PW = $clog2(PERIOD);
    localparam int unsigned HW = $clog2(CONFIRM_N + 1);
    localparam int unsigned MW = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          bit_out_q, bit_out_d;
    logic          bit_valid_q, bit_valid_d;
    logic          bit_weak_q, bit_weak_d;

    logic          is_hi, is_lo, peak, boundary;
    logic [PW-1:0] phase_inc;
    logic [HW-1:0] hit_inc;
    logic [MW-1:0] miss_inc;

    assign is_hi     = corr >= CW'(HI_TH);
    assign is_lo     = corr <= CW'(LO_TH);
    assign peak      = is_hi | is_lo;
    assign boundary  = phase_q == PW'(PERIOD - 1);
    assign phase_inc = boundary ? '0 : phase_q + PW'(1);
    assign hit_inc   = hit_q + HW'(1);
    assign miss_inc  = miss_q + MW'(1);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        bit_weak_d  = bit_weak_q;

        if (resync) begin
            state_d = StSearch;
            phase_d = '0;
            hit_d   = '0;
            miss_d  = '0;
        end else if (chip_en) begin
            unique case (state_q)
                StSearch: begin
                    if (peak) begin
                        phase_d = '0;
                        miss_d  = '0;
                        if (CONFIRM_N <= 1) begin
                            state_d     = StLocked;
                            hit_d       = '0;
                            bit_valid_d = 1'b1;
                            bit_out_d   = is_hi;
                            bit_weak_d  = 1'b0;
                        end else begin
                            state_d = StVerify;
                            hit_d   = HW'(1);
                        end
                    end
                end
                StVerify: begin
                    phase_d = phase_inc;
                    if (boundary) begin
                        if (!peak) begin
                            // Miss chip is not reconsidered as a fresh search peak.
                            state_d = StSearch;
                            hit_d   = '0;
                        end else if (hit_inc == HW'(CONFIRM_N)) begin
                            state_d     = StLocked;
                            hit_d       = '0;
                            miss_d      = '0;
                            bit_valid_d = 1'b1;
                            bit_out_d   = is_hi;
                            bit_weak_d  = 1'b0;
                        end else begin
                            hit_d = hit_inc;
                        end
                    end
                end
                StLocked: begin
                    phase_d = phase_inc;
                    if (boundary) begin
                        if (peak) begin
                            miss_d      = '0;
                            bit_valid_d = 1'b1;
                            bit_out_d   = is_hi;
                            bit_weak_d  = 1'b0;
                        end else if (miss_inc == MW'(MISS_MAX)) begin
                            state_d = StSearch;
                            phase_d = '0;
                            hit_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d      = miss_inc;
                            bit_valid_d = 1'b1;
                            bit_out_d   = corr > CW'(PERIOD);
                            bit_weak_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StSearch;
                    phase_d = '0;
                    hit_d   = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSearch;
            phase_q     <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_weak_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            bit_weak_q  <= bit_weak_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign bit_weak  = bit_weak_q;
    assign locked    = state_q == StLocked;
    assign state_o   = state_q;

endmodule

// File: tb/tb_dsss_sync_ctrl.sv
// Directed bench for dsss_sync_ctrl at default parameters; one chip per call, outputs
// sampled 1 time unit after the clock edge that consumed the chip.
module tb_dsss_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       chip_en = 1'b0;
    logic [7:0] corr = 8'd0;
    logic       resync = 1'b0;
    logic       bit_out, bit_valid, bit_weak, locked;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsss_sync_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .chip_en   (chip_en),
        .corr      (corr),
        .resync    (resync),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_weak  (bit_weak),
        .locked    (locked),
        .state_o   (state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] c, input logic en, input logic rs);
        corr    = c;
        chip_en = en;
        resync  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chip(input logic [7:0] c);
        step(c, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) chip(8'd20);
    endtask

    // Outputs after a boundary decision: state, locked, strobe, bit, weak.
    task automatic expect_out(input string tag, input logic [1:0] st, input logic lk,
                              input logic bv, input logic bo, input logic bw);
        check({tag, ".state"}, state_o, st);
        check({tag, ".locked"}, locked, lk);
        check({tag, ".bit_valid"}, bit_valid, bv);
        if (bv) begin
            check({tag, ".bit_out"}, bit_out, bo);
            check({tag, ".bit_weak"}, bit_weak, bw);
        end
    endtask

    initial begin
        // 1: reset, then a strong score held with chip_en low must not start acquisition
        rst = 1'b1;
        step(8'd0, 1'b0, 1'b0);
        step(8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(8'd62, 1'b0, 1'b0);
        expect_out("t1_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1.bit_out", bit_out, 1'b0);
        check("t1.bit_weak", bit_weak, 1'b0);

        // Just-inside-threshold scores are not peaks
        chip(8'd55);
        check("no_peak_55", state_o, 2'd0);
        chip(8'd7);
        check("no_peak_7", state_o, 2'd0);

        // 2: acquire, confirm after 31 chips, then a strong zero
        chip(8'd62);
        expect_out("t2_t0", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(30);
        expect_out("t2_pre", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chip(8'd62);
        expect_out("t2_lock", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chip(8'd20);
        check("t2_strobe_1clk", bit_valid, 1'b0);
        idle(29);
        chip(8'd0);
        expect_out("t2_zero", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

        // 5: off-boundary peak ignored; exact HI_TH at next boundary is a strong 1
        idle(4);
        chip(8'd62);
        expect_out("t5_off", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(25);
        chip(8'd56);
        expect_out("t5_bnd", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

        // Exact LO_TH at boundary is a strong 0
        idle(30);
        chip(8'd6);
        expect_out("lo_bnd", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

        // 4: weak boundaries; corr=31 is not > PERIOD so decides 0; third miss drops lock
        idle(30);
        chip(8'd40);
        expect_out("t4_w1", 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(30);
        chip(8'd31);
        expect_out("t4_w2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(30);
        chip(8'd40);
        expect_out("t4_w3", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // A strong boundary clears the miss count
        chip(8'd62);
        idle(30);
        chip(8'd62);
        check("mc_lock", state_o, 2'd2);
        idle(30);
        chip(8'd40);
        idle(30);
        chip(8'd62);
        idle(30);
        chip(8'd40);
        idle(30);
        chip(8'd40);
        expect_out("mc_w2", 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(30);
        chip(8'd40);
        expect_out("mc_drop", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: failed confirmation returns to search without re-evaluating that chip
        chip(8'd62);
        idle(30);
        chip(8'd30);
        expect_out("t3_fail", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chip(8'd20);
        check("t3_stay", state_o, 2'd0);

        // 6: chip_en low for 10 clk mid-VERIFY shifts the boundary by 10 clk
        chip(8'd62);
        idle(10);
        for (int i = 0; i < 10; i++) step(8'd62, 1'b0, 1'b0);
        check("t6_hold", state_o, 2'd1);
        idle(20);
        check("t6_pre", state_o, 2'd1);
        chip(8'd62);
        expect_out("t6_lock", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

        // resync from LOCKED, and resync beating a peak in SEARCH and VERIFY
        step(8'd20, 1'b0, 1'b1);
        expect_out("rs_lock", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'd62, 1'b1, 1'b1);
        check("rs_search", state_o, 2'd0);
        chip(8'd62);
        check("rs_verify_pre", state_o, 2'd1);
        step(8'd62, 1'b1, 1'b1);
        check("rs_verify", state_o, 2'd0);

        // Resync clears phase: fresh acquisition confirms exactly 31 chips later
        chip(8'd0);
        idle(30);
        chip(8'd62);
        expect_out("rs_reacq", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

        // rst at a boundary drops the in-flight bit
        idle(30);
        rst = 1'b1;
        chip(8'd62);
        rst = 1'b0;
        expect_out("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
